fir_mac_engine: RTL

//  Time-multiplexed multiply-accumulate stage directly downstream of shiftchain.

---
 rtl/fir_mac_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: time-multiplexed FIR multiply-accumulate stage.
// Accepts one sample per handshake (pulsing shift_en so the upstream shift chain
// captures it), then walks every tap with a single multiplier against a
// programmable coefficient bank, rounds half up, saturates, and presents the
// result on a valid/ready output.
module fir_mac_engine #(
    parameter int WORD_WIDTH  = 16,
    parameter int CHAIN_DEPTH = 53,
    parameter int COEF_WIDTH  = 16,
    parameter int FRAC_BITS   = 15,
    parameter int OUT_WIDTH   = 16,
    parameter int ACC_WIDTH   = WORD_WIDTH + COEF_WIDTH + $clog2(CHAIN_DEPTH)
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic                                      shift_en,
    input  logic [CHAIN_DEPTH-1:0][WORD_WIDTH-1:0]    taps,
    input  logic                                      coef_we,
    input  logic [$clog2(CHAIN_DEPTH)-1:0]            coef_addr,
    input  logic signed [COEF_WIDTH-1:0]              coef_wdata,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [OUT_WIDTH-1:0]               y,
    output logic                                      sat,
    output logic                                      busy
);

    localparam int ADDR_WIDTH = $clog2(CHAIN_DEPTH);
    localparam int PROD_WIDTH = WORD_WIDTH + COEF_WIDTH;

    localparam logic [ADDR_WIDTH-1:0]        LAST_IDX   = ADDR_WIDTH'(CHAIN_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]          DEPTH_EXT  = (ADDR_WIDTH + 1)'(CHAIN_DEPTH);
    localparam logic signed [ACC_WIDTH-1:0]  ROUND_HALF = ACC_WIDTH'(64'sd1 <<< (FRAC_BITS - 1));
    localparam logic signed [ACC_WIDTH-1:0]  OUT_MAX    = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0]  OUT_MIN    = ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [ADDR_WIDTH-1:0]          idx;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [COEF_WIDTH-1:0]   coef [CHAIN_DEPTH];

    logic signed [WORD_WIDTH-1:0]   tap_sel;
    logic signed [COEF_WIDTH-1:0]   coef_sel;
    logic signed [PROD_WIDTH-1:0]   product;
    logic signed [ACC_WIDTH-1:0]    product_ext;
    logic signed [ACC_WIDTH-1:0]    rounded;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic signed [OUT_WIDTH-1:0]    clipped_y;
    logic                           clipped_sat;
    logic                           coef_write_ok;

    // The chain may only move while the engine is waiting for a sample, so taps
    // are frozen for the whole accumulation.
    assign shift_en = in_valid & in_ready;

    // Single shared multiplier: one tap/coefficient pair per ACCUM cycle.
    assign tap_sel     = $signed(taps[idx]);
    assign coef_sel    = coef[idx];
    assign product     = tap_sel * coef_sel;
    assign product_ext = {{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product};

    // Round half up, then arithmetic shift back to output scaling.
    assign rounded = acc + ROUND_HALF;
    assign shifted = rounded >>> FRAC_BITS;

    // Writes land only while idle and only inside the bank.
    assign coef_write_ok = coef_we && (state == IDLE) && ({1'b0, coef_addr} < DEPTH_EXT);

    // Saturate the scaled sum into the signed output range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        clipped_y   = shifted[OUT_WIDTH-1:0];
        clipped_sat = 1'b0;
        if (shifted > OUT_MAX) begin
            clipped_y   = OUT_MAX[OUT_WIDTH-1:0];
            clipped_sat = 1'b1;
        end else if (shifted < OUT_MIN) begin
            clipped_y   = OUT_MIN[OUT_WIDTH-1:0];
            clipped_sat = 1'b1;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == LAST_IDX) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register; reset overrides any in-flight computation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: clear on accept, accumulate per tap, register rounded result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
            idx <= '0;
            y   <= '0;
            sat <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (shift_en) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + product_ext;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                ROUND: begin
                    y   <= clipped_y;
                    sat <= clipped_sat;
                end
                default: begin
                    // OUT holds y/sat until the consumer takes them.
                end
            endcase
        end
    end

    // Coefficient bank: cleared on reset, written only while idle.
    always_ff @(posedge clk) begin
        // NOTE: the bank must read zero after reset, so it is built from resettable flops rather than a RAM macro.
        if (!resetn) begin
            for (int i = 0; i < CHAIN_DEPTH; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_write_ok) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

endmodule
